// File: rtl/sblk_ctrl.sv
// sblk_ctrl: SuperBlock buffer sequencer: activation load, lock-step read sweep, delayed psum write-back
module sblk_ctrl #(
  parameter int N_TILE       = 40,
  parameter int WID_ACT      = 16,
  parameter int WID_ACTADDR  = 6,
  parameter int WID_WADDR    = 10,
  parameter int WID_PSUMADDR = 9,
  parameter int PSUM_LAT     = 48
) (
  input  logic                    clk_l,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WID_ACTADDR-1:0]  cfg_act_len,
  input  logic [WID_PSUMADDR:0]   cfg_psum_len,
  input  logic [2*WID_ACT-1:0]    s_act_data,
  input  logic                    s_act_valid,
  output logic                    s_act_ready,
  output logic                    busy,
  output logic                    done,
  output logic [2*WID_ACT-1:0]    act_data_in,
  output logic [N_TILE-1:0]       act_wr_en,
  output logic [WID_ACTADDR-2:0]  act_wr_addr_hbit,
  output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
  output logic [WID_WADDR-1:0]    w_rd_addr,
  output logic [WID_PSUMADDR-1:0] psum_rd_addr,
  output logic                    psum_wr_en,
  output logic [WID_PSUMADDR-1:0] psum_wr_addr
);
  localparam int TW = N_TILE > 1 ? $clog2(N_TILE) : 1;
  localparam int AW = WID_ACTADDR - 1;
  localparam int DW = $clog2(PSUM_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [WID_ACTADDR-1:0] k_len, k_last;
  logic [WID_PSUMADDR:0] p_len, p_last;
  logic [TW-1:0] tile;
  logic [AW-1:0] row;
  logic [DW-1:0] dcnt;
  logic acc, row_end, last_beat, issue, k_end, p_end, last_rd;
  logic sr_en [PSUM_LAT];
  logic [WID_PSUMADDR-1:0] sr_addr [PSUM_LAT];
  assign k_last    = k_len - WID_ACTADDR'(1);
  assign p_last    = p_len - (WID_PSUMADDR+1)'(1);
  assign acc       = s_act_ready & s_act_valid;
  assign row_end   = {1'b0, row} == k_last;
  assign last_beat = acc && row_end && tile == TW'(N_TILE - 1);
  assign issue     = state == COMPUTE;
  assign k_end     = {1'b0, act_rd_addr_hbit} == k_last;
  assign p_end     = {1'b0, psum_rd_addr} == p_last;
  assign last_rd   = issue && k_end && p_end;
  assign psum_wr_en   = sr_en[PSUM_LAT-1];
  assign psum_wr_addr = sr_addr[PSUM_LAT-1];
  always_ff @(posedge clk_l or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    s_act_ready = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = (cfg_act_len == '0 || cfg_psum_len == '0) ? DONE : LOAD;
      LOAD:    begin busy = 1'b1; s_act_ready = 1'b1; if (last_beat) state_nx = COMPUTE; end
      COMPUTE: begin busy = 1'b1; if (last_rd) state_nx = DRAIN; end
      DRAIN:   begin busy = 1'b1; if (dcnt == DW'(PSUM_LAT - 1)) state_nx = DONE; end
      DONE:    begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_l or negedge rst_n)
    if (!rst_n) begin
      k_len            <= '0;
      p_len            <= '0;
      tile             <= '0;
      row              <= '0;
      dcnt             <= '0;
      act_data_in      <= '0;
      act_wr_en        <= '0;
      act_wr_addr_hbit <= '0;
      act_rd_addr_hbit <= '0;
      psum_rd_addr     <= '0;
      w_rd_addr        <= '0;
    end else begin
      if (state == IDLE && start) begin
        k_len            <= cfg_act_len;
        p_len            <= cfg_psum_len;
        tile             <= '0;
        row              <= '0;
        act_rd_addr_hbit <= '0;
        psum_rd_addr     <= '0;
        w_rd_addr        <= '0;
      end
      act_wr_en <= acc ? N_TILE'(1) << tile : '0;
      if (acc) begin
        act_data_in      <= s_act_data;
        act_wr_addr_hbit <= row;
        row              <= row_end ? '0 : row + AW'(1);
        tile             <= row_end ? tile + TW'(1) : tile;
      end
      // the final read is not advanced so addresses hold through DRAIN
      if (issue && !last_rd) begin
        w_rd_addr        <= w_rd_addr + WID_WADDR'(1);
        psum_rd_addr     <= p_end ? '0 : psum_rd_addr + WID_PSUMADDR'(1);
        act_rd_addr_hbit <= p_end ? act_rd_addr_hbit + AW'(1) : act_rd_addr_hbit;
      end
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
    end
  always_ff @(posedge clk_l or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < PSUM_LAT; i++) begin
        sr_en[i]   <= 1'b0;
        sr_addr[i] <= '0;
      end
    end else begin
      sr_en[0]   <= issue;
      sr_addr[0] <= issue ? psum_rd_addr : '0;
      for (int i = PSUM_LAT - 1; i > 0; i--) begin
        sr_en[i]   <= sr_en[i-1];
        sr_addr[i] <= sr_addr[i-1];
      end
    end
endmodule

// File: tb/tb_sblk_ctrl.sv
// tb_sblk_ctrl: randomized bench for sblk_ctrl against a cycle-level behavioural model
module tb_sblk_ctrl;
  localparam int NT = 4, WA = 16, AA = 6, WW = 10, PA = 9, LAT = 5;
  logic clk_l = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [AA-1:0] cfg_act_len = '0;
  logic [PA:0] cfg_psum_len = '0;
  logic [2*WA-1:0] s_act_data = '0;
  logic s_act_valid = 1'b0;
  logic s_act_ready, busy, done, psum_wr_en;
  logic [2*WA-1:0] act_data_in;
  logic [NT-1:0] act_wr_en;
  logic [AA-2:0] act_wr_addr_hbit, act_rd_addr_hbit;
  logic [WW-1:0] w_rd_addr;
  logic [PA-1:0] psum_rd_addr, psum_wr_addr;
  int checks = 0, failures = 0;

  sblk_ctrl #(.N_TILE(NT), .WID_ACT(WA), .WID_ACTADDR(AA), .WID_WADDR(WW),
              .WID_PSUMADDR(PA), .PSUM_LAT(LAT)) dut (
    .clk_l(clk_l), .rst_n(rst_n), .start(start), .cfg_act_len(cfg_act_len),
    .cfg_psum_len(cfg_psum_len), .s_act_data(s_act_data), .s_act_valid(s_act_valid),
    .s_act_ready(s_act_ready), .busy(busy), .done(done), .act_data_in(act_data_in),
    .act_wr_en(act_wr_en), .act_wr_addr_hbit(act_wr_addr_hbit),
    .act_rd_addr_hbit(act_rd_addr_hbit), .w_rd_addr(w_rd_addr),
    .psum_rd_addr(psum_rd_addr), .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr));

  always #5 clk_l = ~clk_l;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 compute, 3 drain, 4 done; addresses from div/mod of beat/read index
  typedef struct {int due; int addr;} wr_t;
  wr_t wq[$];
  int ph, cyc, mk, mp, beats, j, last_wr;
  logic e_busy, e_done, e_ready, e_pwen;
  logic [NT-1:0] e_wen;
  logic [2*WA-1:0] e_data;
  int e_whbit, e_rhbit, e_prd, e_w, e_pwaddr;

  always @(posedge clk_l or negedge rst_n) begin
    int nph;
    if (!rst_n) begin
      ph = 0; cyc = 0; last_wr = -1; wq.delete();
      e_busy = 0; e_done = 0; e_ready = 0; e_pwen = 0; e_wen = '0; e_data = '0;
      e_whbit = 0; e_rhbit = 0; e_prd = 0; e_w = 0; e_pwaddr = 0;
    end else begin
      nph = ph;
      cyc++;
      e_wen = '0;
      case (ph)
        0: if (start) begin
             mk = int'(cfg_act_len); mp = int'(cfg_psum_len); beats = 0; j = 0;
             nph = (mk == 0 || mp == 0) ? 4 : 1;
           end
        1: if (s_act_valid) begin
             e_wen = NT'(1) << (beats / mk); e_whbit = beats % mk; e_data = s_act_data;
             beats++;
             if (beats == NT * mk) begin nph = 2; e_rhbit = 0; e_prd = 0; e_w = 0; end
           end
        2: begin
             wq.push_back('{cyc - 1 + LAT, j % mp});
             j++;
             if (j == mk * mp) nph = 3;
             else begin e_rhbit = j / mp; e_prd = j % mp; e_w = j % 1024; end
           end
        3: if (wq.size() == 0 && last_wr == cyc - 1) nph = 4;
        default: nph = 0;
      endcase
      ph = nph;
      e_busy = ph >= 1 && ph <= 3; e_done = ph == 4; e_ready = ph == 1;
      e_pwen = 0;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        e_pwen = 1; e_pwaddr = wq[0].addr; last_wr = cyc;
        void'(wq.pop_front());
      end
    end
  end

  always @(negedge clk_l) if (rst_n) begin
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("s_act_ready", s_act_ready, e_ready);
    chk("act_wr_en", act_wr_en, e_wen);
    if (e_wen != '0) begin
      chk("act_data_in", act_data_in, e_data);
      chk("act_wr_addr_hbit", act_wr_addr_hbit, e_whbit);
    end
    chk("psum_wr_en", psum_wr_en, e_pwen);
    if (e_pwen) chk("psum_wr_addr", psum_wr_addr, e_pwaddr);
    if (ph == 2 || ph == 3) begin
      chk("act_rd_addr_hbit", act_rd_addr_hbit, e_rhbit);
      chk("psum_rd_addr", psum_rd_addr, e_prd);
      chk("w_rd_addr", w_rd_addr, e_w);
    end
  end

  logic [NT-1:0] wen_log[$];
  int wh_log[$], prd_log[$], rh_log[$], w_log[$];
  int n_pw, n_done, n_ready, t_done, max_w, extra;

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, s_act_ready, 0);
    chk({tag, "_data"}, act_data_in, 0);
    chk({tag, "_wen"}, act_wr_en, 0);
    chk({tag, "_whbit"}, act_wr_addr_hbit, 0);
    chk({tag, "_rhbit"}, act_rd_addr_hbit, 0);
    chk({tag, "_waddr"}, w_rd_addr, 0);
    chk({tag, "_prd"}, psum_rd_addr, 0);
    chk({tag, "_pwen"}, psum_wr_en, 0);
    chk({tag, "_pwaddr"}, psum_wr_addr, 0);
  endtask

  task automatic run_pass(input int k, input int p, input int vmode, input int spam);
    int t;
    wen_log.delete(); wh_log.delete(); prd_log.delete(); rh_log.delete(); w_log.delete();
    n_pw = 0; n_done = 0; n_ready = 0; t_done = -1; max_w = 0; extra = 0; t = 0;
    @(negedge clk_l);
    start = 1'b1; cfg_act_len = AA'(k); cfg_psum_len = (PA+1)'(p);
    s_act_valid = vmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    s_act_data = $urandom;
    do begin
      @(negedge clk_l);
      t++;
      if (act_wr_en != '0) begin wen_log.push_back(act_wr_en); wh_log.push_back(int'(act_wr_addr_hbit)); end
      if (ph == 2) begin
        prd_log.push_back(int'(psum_rd_addr)); rh_log.push_back(int'(act_rd_addr_hbit));
        w_log.push_back(int'(w_rd_addr));
        if (int'(w_rd_addr) > max_w) max_w = int'(w_rd_addr);
      end
      if (psum_wr_en) n_pw++;
      if (s_act_ready) n_ready++;
      if (done) begin n_done++; t_done = t; end
      start = spam != 0 ? (done ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      s_act_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~s_act_valid : 1'($urandom_range(0, 1));
      s_act_data = $urandom;
    end while (!done && t < 4000);
    if (!done) begin
      checks++; failures++;
      $display("FAIL pass_timeout: no done within %0d cycles (K=%0d P=%0d)", t, k, p);
    end
    @(negedge clk_l);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk_l);
      if (busy || done) extra++;
    end
  endtask

  int exp_wen[8] = '{1, 1, 2, 2, 4, 4, 8, 8};
  int exp_wh[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
  int exp_prd[6] = '{0, 1, 2, 0, 1, 2};
  int exp_rh[6]  = '{0, 0, 0, 1, 1, 1};

  task automatic chk_k2p3(input string tag, input int ready_cycles, input int done_at);
    chk({tag, "_nwen"}, wen_log.size(), 8);
    for (int i = 0; i < 8 && i < wen_log.size(); i++) begin
      chk({tag, "_wen_seq"}, wen_log[i], exp_wen[i]);
      chk({tag, "_wh_seq"}, wh_log[i], exp_wh[i]);
    end
    chk({tag, "_nrd"}, prd_log.size(), 6);
    for (int i = 0; i < 6 && i < prd_log.size(); i++) begin
      chk({tag, "_prd_seq"}, prd_log[i], exp_prd[i]);
      chk({tag, "_rh_seq"}, rh_log[i], exp_rh[i]);
      chk({tag, "_w_seq"}, w_log[i], i);
    end
    chk({tag, "_npw"}, n_pw, 6);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_ready_cycles"}, n_ready, ready_cycles);
    chk({tag, "_done_at"}, t_done, done_at);
  endtask

  initial begin
    int t;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_l);
    chk_zero("reset");
    rst_n = 1'b1;

    run_pass(2, 3, 0, 0);
    chk_k2p3("full", 8, 20);
    run_pass(2, 3, 1, 0);
    chk_k2p3("bubble", 16, 28);

    run_pass(0, 3, 2, 0);
    chk("k0_nwen", wen_log.size(), 0);
    chk("k0_npw", n_pw, 0);
    chk("k0_done_at", t_done, 1);
    run_pass(2, 0, 2, 0);
    chk("p0_nwen", wen_log.size(), 0);
    chk("p0_npw", n_pw, 0);
    chk("p0_done_at", t_done, 1);

    run_pass(32, 32, 2, 0);
    chk("big_nwen", wen_log.size(), 128);
    chk("big_npw", n_pw, 1024);
    chk("big_max_w", max_w, 1023);
    chk("big_ndone", n_done, 1);

    run_pass(3, 2, 2, 1);
    chk("spam_ndone", n_done, 1);
    chk("spam_ignored", extra, 0);

    @(negedge clk_l);
    start = 1'b1; cfg_act_len = 2; cfg_psum_len = 4; s_act_valid = 1'b1;
    @(negedge clk_l);
    start = 1'b0;
    t = 0;
    while (ph != 2 && t < 100) begin @(negedge clk_l); t++; end
    chk("midrst_reached_compute", ph, 2);
    repeat (2) @(negedge clk_l);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk_l);
    rst_n = 1'b1;
    t = 0;
    repeat (20) begin
      @(negedge clk_l);
      if (psum_wr_en || done || busy) t++;
    end
    chk("midrst_quiet", t, 0);
    run_pass(2, 3, 0, 0);
    chk_k2p3("after_rst", 8, 20);

    for (int i = 0; i < 8; i++) begin
      run_pass($urandom_range(0, 6), $urandom_range(0, 7), 2, $urandom_range(0, 1));
      chk("rand_ndone", n_done, 1);
      chk("rand_ignored", extra, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
